i2c_slave_fsm: RTL and testbench
================================

I2C_SLAVE_FSM -- requirements
Module: i2c_slave_fsm

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 7, the slave address width.
REQ-002 SHALL have parameter DATA_LEN, default 8, the data byte width.
REQ-003 SHALL have parameter SLAVE_ADDR, default 7'b1011011, the address this slave responds to.
REQ-004 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port scl, input, 1: bus clock, asynchronous to clk.
REQ-007 Port sda_in, input, 1: bus data as sampled from the pulled-up line.
REQ-008 Port sda_oe, output, 1: 1 pulls SDA low; 0 releases it (open-drain).
REQ-009 Port data_tx, input, DATA_LEN: byte returned on read transfers.
REQ-010 Port tx_req, output, 1: one-cycle pulse when data_tx is latched.
REQ-011 Port rx_data, output, DATA_LEN: last byte received on a write.
REQ-012 Port rx_valid, output, 1: one-cycle pulse when rx_data updates.
REQ-013 Port busy, output, 1: high from an address match until STOP, START or NACK-exit.
REQ-014 Port state_slave, output, 3: current FSM state code.

Function
REQ-015 scl and sda_in SHALL each pass through a 2-flop synchronizer, followed by a registered edge detector producing rise and fall pulses.
REQ-016 START SHALL be detected when synced sda falls while synced scl is high; STOP when synced sda rises while synced scl is high.
REQ-017 FSM states, with codes: IDLE=0, ADDR=1, ADDR_ACK=2, WRITE=3, WRITE_ACK=4, READ=5, READ_ACK=6.
REQ-018 START in any state SHALL enter ADDR, clear the bit counter and release sda_oe (this covers repeated START).
REQ-019 STOP in any state SHALL enter IDLE and release sda_oe.
REQ-020 Bits SHALL be sampled MSB-first on each scl rise; sda_oe SHALL change only on an scl fall, and no later than 3 clk cycles after the raw scl fall.
REQ-021 In ADDR, ADDR_LEN address bits plus the R/W bit SHALL be shifted in; the FSM moves to ADDR_ACK on the 8th rise.
REQ-022 In ADDR_ACK on an address match: the next scl fall SHALL assert sda_oe, and busy SHALL be set.
REQ-023 In ADDR_ACK on an address mismatch: the next fall SHALL return the FSM to IDLE with sda_oe=0, ignoring traffic until the next START.
REQ-024 ACK release: the scl fall after the ACK bit SHALL release sda_oe (W=0 path to WRITE), or drive data_tx[7] (R=1 path to READ).
REQ-025 WRITE: on the 8th rise, rx_data SHALL load the shifted byte, rx_valid SHALL pulse once, and the FSM moves to WRITE_ACK.
REQ-026 WRITE_ACK SHALL drive the ACK low for one bit, then return to WRITE for the next byte; there is no byte limit.
REQ-027 READ: tx_req SHALL pulse and data_tx SHALL be latched on the fall that starts bit 7.
REQ-028 READ bit drive: sda_oe SHALL equal the inverse of the current bit; after the 8th bit's fall sda_oe is released and the FSM enters READ_ACK.
REQ-029 READ_ACK SHALL sample the master's ACK on the scl rise: sda=0 returns to READ for the next byte; sda=1 (NACK) goes to IDLE, releases sda_oe and clears busy.
REQ-030 The bit counter SHALL be 3 bits and wrap 7->0 at each byte boundary.
REQ-031 rx_valid and tx_req SHALL never be asserted in the same cycle.

Reset
REQ-032 rst SHALL force: state IDLE, sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, counters and shift registers 0, synchronizer flops 1 (idle bus).
REQ-033 Reset mid-transfer SHALL release SDA within the same cycle (asynchronous), and the block SHALL wait for a new START.

Structure
REQ-034 Package i2c_pkg SHALL hold the state encoding, ADDR_LEN and DATA_LEN defaults, and the default SLAVE_ADDR.
REQ-035 Sub-module i2c_line_sync (2-flop sync + rise/fall detect) SHALL be instantiated once per line (scl, sda).
REQ-036 The block SHALL interoperate with fsm_master configured with T_LOW=6, T_HIGH=4 and SETUP_SDA=3 clk cycles.

Verification
REQ-037 Write: START, addr 1011011 W, data 0xAC, STOP -> two ACKs seen on SDA; rx_data=0xAC; exactly one rx_valid pulse.
REQ-038 Mismatch: address 0101010 -> sda_oe stays 0 throughout; busy stays 0; no rx_valid pulse.
REQ-039 Read: addr 1011011 R, data_tx=0x42, master NACK -> SDA carries 01000010; one tx_req pulse; FSM reaches IDLE and busy=0.
REQ-040 Repeated START: write byte 0x1D, then START, read addr -> FSM passes through ADDR; rx_data=0x1D is retained.
REQ-041 Abort: STOP after 4 data bits -> IDLE immediately; no rx_valid pulse; sda_oe=0.
REQ-042 Reset: rst asserted while sda_oe=1 during ACK -> sda_oe=0 asynchronously; all outputs take their reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave: state encoding and default geometry.
package i2c_pkg;

   localparam int         ADDR_LEN_DEF   = 7;
   localparam int         DATA_LEN_DEF   = 8;
   localparam logic [6:0] SLAVE_ADDR_DEF = 7'b1011011;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_WRITE     = 3'd3,
      ST_WRITE_ACK = 3'd4,
      ST_READ      = 3'd5,
      ST_READ_ACK  = 3'd6
   } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one bus line plus edge detect on the synced value.
module i2c_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic line,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync_q;
   logic prev_q;

   // Flops preset to 1 so an idle (pulled-up) bus produces no edges after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta   <= line;
         sync_q <= meta;
         prev_q <= sync_q;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_slave_fsm.sv
// I2C slave: address match, byte write to rx_data, byte read from data_tx.
//
// state        | meaning
// IDLE         | ignore bus until START
// ADDR         | shift in 7-bit address + R/W
// ADDR_ACK     | drive ACK on match (phase 0), then release/drive first read bit (phase 1)
// WRITE        | shift in a data byte from the master
// WRITE_ACK    | drive ACK for the received byte
// READ         | drive data byte MSB-first
// READ_ACK     | sample master ACK/NACK, start next byte on ACK
module i2c_slave_fsm
   import i2c_pkg::*;
#(
   parameter int                  ADDR_LEN   = ADDR_LEN_DEF,
   parameter int                  DATA_LEN   = DATA_LEN_DEF,
   parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = SLAVE_ADDR_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                scl,
   input  logic                sda_in,
   output logic                sda_oe,
   input  logic [DATA_LEN-1:0] data_tx,
   output logic                tx_req,
   output logic [DATA_LEN-1:0] rx_data,
   output logic                rx_valid,
   output logic                busy,
   output logic [2:0]          state_slave
);

   localparam logic [2:0] LAST_ADDR_BIT = 3'(ADDR_LEN);
   localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_LEN - 1);

   logic scl_s, scl_rise, scl_fall;
   logic sda_s, sda_rise, sda_fall;

   i2c_line_sync u_scl_sync (
      .clk  (clk),
      .rst  (rst),
      .line (scl),
      .sync (scl_s),
      .rise (scl_rise),
      .fall (scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clk  (clk),
      .rst  (rst),
      .line (sda_in),
      .sync (sda_s),
      .rise (sda_rise),
      .fall (sda_fall)
   );

   logic start_det, stop_det;
   assign start_det = sda_fall & scl_s;
   assign stop_det  = sda_rise & scl_s;

   state_t              state;
   logic [2:0]          bit_cnt;
   logic [ADDR_LEN:0]   addr_sh;
   logic [DATA_LEN-1:0] data_sh;
   logic [DATA_LEN-1:0] tx_sh;
   logic                ack_phase;
   logic                addr_match;
   logic                rw;

   logic [ADDR_LEN:0]   addr_next;
   logic [DATA_LEN-1:0] data_next;
   assign addr_next = {addr_sh[ADDR_LEN-1:0], sda_s};
   assign data_next = {data_sh[DATA_LEN-2:0], sda_s};

   assign state_slave = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         addr_sh    <= '0;
         data_sh    <= '0;
         tx_sh      <= '0;
         ack_phase  <= 1'b0;
         addr_match <= 1'b0;
         rw         <= 1'b0;
         sda_oe     <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         tx_req     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         if (start_det) begin
            state     <= ST_ADDR;
            bit_cnt   <= '0;
            addr_sh   <= '0;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
         end else if (stop_det) begin
            state     <= ST_IDLE;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               ST_ADDR: begin
                  if (scl_rise) begin
                     addr_sh <= addr_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == LAST_ADDR_BIT) begin
                        state      <= ST_ADDR_ACK;
                        ack_phase  <= 1'b0;
                        addr_match <= (addr_next[ADDR_LEN:1] == SLAVE_ADDR);
                        rw         <= addr_next[0];
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!ack_phase) begin
                        if (addr_match) begin
                           sda_oe    <= 1'b1;
                           busy      <= 1'b1;
                           ack_phase <= 1'b1;
                        end else begin
                           state  <= ST_IDLE;
                           sda_oe <= 1'b0;
                        end
                     end else begin
                        ack_phase <= 1'b0;
                        bit_cnt   <= '0;
                        if (rw) begin
                           state  <= ST_READ;
                           tx_sh  <= data_tx;
                           tx_req <= 1'b1;
                           sda_oe <= ~data_tx[DATA_LEN-1];
                        end else begin
                           state  <= ST_WRITE;
                           sda_oe <= 1'b0;
                        end
                     end
                  end
               end
               ST_WRITE: begin
                  if (scl_rise) begin
                     data_sh <= data_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == LAST_DATA_BIT) begin
                        rx_data   <= data_next;
                        rx_valid  <= 1'b1;
                        state     <= ST_WRITE_ACK;
                        ack_phase <= 1'b0;
                     end
                  end
               end
               ST_WRITE_ACK: begin
                  if (scl_fall) begin
                     if (!ack_phase) begin
                        sda_oe    <= 1'b1;
                        ack_phase <= 1'b1;
                     end else begin
                        sda_oe    <= 1'b0;
                        ack_phase <= 1'b0;
                        state     <= ST_WRITE;
                     end
                  end
               end
               ST_READ: begin
                  // bit_cnt counts rises; back at 0 means all bits have been clocked out
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 3'd0) begin
                        sda_oe    <= 1'b0;
                        state     <= ST_READ_ACK;
                        ack_phase <= 1'b0;
                     end else begin
                        sda_oe <= ~tx_sh[DATA_LEN-2];
                        tx_sh  <= tx_sh << 1;
                     end
                  end
               end
               ST_READ_ACK: begin
                  if (scl_rise && !ack_phase) begin
                     if (sda_s) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        sda_oe <= 1'b0;
                     end else begin
                        ack_phase <= 1'b1;
                     end
                  end else if (scl_fall && ack_phase) begin
                     ack_phase <= 1'b0;
                     bit_cnt   <= '0;
                     state     <= ST_READ;
                     tx_sh     <= data_tx;
                     tx_req    <= 1'b1;
                     sda_oe    <= ~data_tx[DATA_LEN-1];
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Directed bench for i2c_slave_fsm: a simple bus master with T_LOW=6, T_HIGH=4, SDA setup 3.
module tb_i2c_slave_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe;
   logic [7:0] data_tx = 8'h00;
   logic       tx_req;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic [2:0] state_slave;

   int checks = 0;
   int fails  = 0;

   int rx_cnt = 0, tx_cnt = 0, oe_cnt = 0, busy_cnt = 0, addr_cnt = 0;

   always #5 clk = ~clk;

   assign sda_line = sda_m & ~sda_oe;

   i2c_slave_fsm dut (
      .clk         (clk),
      .rst         (rst),
      .scl         (scl_m),
      .sda_in      (sda_line),
      .sda_oe      (sda_oe),
      .data_tx     (data_tx),
      .tx_req      (tx_req),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .busy        (busy),
      .state_slave (state_slave)
   );

   always @(negedge clk) begin
      if (rx_valid) rx_cnt++;
      if (tx_req) tx_cnt++;
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (state_slave == 3'd1) addr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_bit(input logic b, output logic s);
      scl_m = 1'b0;
      tick(3);
      sda_m = b;
      tick(3);
      scl_m = 1'b1;
      tick(2);
      s = sda_line;
      tick(2);
   endtask

   task automatic bus_start();
      sda_m = 1'b0;
      tick(4);
   endtask

   task automatic bus_rstart();
      scl_m = 1'b0;
      tick(3);
      sda_m = 1'b1;
      tick(3);
      scl_m = 1'b1;
      tick(4);
      sda_m = 1'b0;
      tick(4);
   endtask

   task automatic bus_stop();
      scl_m = 1'b0;
      tick(3);
      sda_m = 1'b0;
      tick(3);
      scl_m = 1'b1;
      tick(4);
      sda_m = 1'b1;
      tick(6);
   endtask

   task automatic send_byte(input logic [7:0] v);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(v[i], s);
   endtask

   task automatic recv_byte(output logic [7:0] v);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         v[i] = s;
      end
   endtask

   initial begin
      logic       ack;
      logic [7:0] rd;
      int r0, t0, o0, b0, a0;

      // reset values
      tick(3);
      check("rst_state", 32'(state_slave), 32'd0);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_tx_req", 32'(tx_req), 32'd0);
      rst = 1'b0;
      tick(5);

      // write 0xAC to 1011011
      r0 = rx_cnt;
      bus_start();
      send_byte(8'hB6);
      bus_bit(1'b1, ack);
      check("wr_addr_ack", 32'(ack), 32'd0);
      check("wr_busy", 32'(busy), 32'd1);
      send_byte(8'hAC);
      bus_bit(1'b1, ack);
      check("wr_data_ack", 32'(ack), 32'd0);
      bus_stop();
      check("wr_rx_data", 32'(rx_data), 32'hAC);
      check("wr_rx_pulses", 32'(rx_cnt - r0), 32'd1);
      check("wr_idle", 32'(state_slave), 32'd0);
      check("wr_busy_clear", 32'(busy), 32'd0);

      // address mismatch 0101010
      r0 = rx_cnt; o0 = oe_cnt; b0 = busy_cnt;
      bus_start();
      send_byte(8'h54);
      bus_bit(1'b1, ack);
      check("mm_no_ack", 32'(ack), 32'd1);
      send_byte(8'h3C);
      bus_bit(1'b1, ack);
      bus_stop();
      check("mm_oe_never", 32'(oe_cnt - o0), 32'd0);
      check("mm_busy_never", 32'(busy_cnt - b0), 32'd0);
      check("mm_rx_pulses", 32'(rx_cnt - r0), 32'd0);
      check("mm_rx_data_kept", 32'(rx_data), 32'hAC);

      // read 0x42, master NACK
      data_tx = 8'h42;
      t0 = tx_cnt;
      bus_start();
      send_byte(8'hB7);
      bus_bit(1'b1, ack);
      check("rd_addr_ack", 32'(ack), 32'd0);
      recv_byte(rd);
      check("rd_data", 32'(rd), 32'h42);
      bus_bit(1'b1, ack);
      check("rd_tx_pulses", 32'(tx_cnt - t0), 32'd1);
      check("rd_idle", 32'(state_slave), 32'd0);
      check("rd_busy_clear", 32'(busy), 32'd0);
      check("rd_oe_released", 32'(sda_oe), 32'd0);
      bus_stop();

      // write 0x1D, repeated START, read
      bus_start();
      send_byte(8'hB6);
      bus_bit(1'b1, ack);
      send_byte(8'h1D);
      bus_bit(1'b1, ack);
      check("rs_data_ack", 32'(ack), 32'd0);
      a0 = addr_cnt;
      bus_rstart();
      data_tx = 8'h99;
      send_byte(8'hB7);
      check("rs_saw_addr", 32'(addr_cnt > a0), 32'd1);
      bus_bit(1'b1, ack);
      check("rs_addr_ack", 32'(ack), 32'd0);
      recv_byte(rd);
      check("rs_read_data", 32'(rd), 32'h99);
      bus_bit(1'b1, ack);
      bus_stop();
      check("rs_rx_kept", 32'(rx_data), 32'h1D);

      // abort after 4 data bits
      r0 = rx_cnt;
      bus_start();
      send_byte(8'hB6);
      bus_bit(1'b1, ack);
      bus_bit(1'b1, ack);
      bus_bit(1'b0, ack);
      bus_bit(1'b1, ack);
      bus_bit(1'b0, ack);
      bus_stop();
      check("ab_idle", 32'(state_slave), 32'd0);
      check("ab_rx_pulses", 32'(rx_cnt - r0), 32'd0);
      check("ab_sda_oe", 32'(sda_oe), 32'd0);
      check("ab_busy", 32'(busy), 32'd0);
      check("ab_rx_kept", 32'(rx_data), 32'h1D);

      // asynchronous reset while driving ACK
      bus_start();
      send_byte(8'hB6);
      scl_m = 1'b0;
      tick(4);
      check("rs_ack_driven", 32'(sda_oe), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_sda_oe", 32'(sda_oe), 32'd0);
      check("arst_state", 32'(state_slave), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_rx_data", 32'(rx_data), 32'h00);
      check("arst_rx_valid", 32'(rx_valid), 32'd0);
      check("arst_tx_req", 32'(tx_req), 32'd0);
      tick(2);
      rst = 1'b0;
      sda_m = 1'b1;
      tick(3);
      scl_m = 1'b1;
      tick(4);
      check("post_rst_idle", 32'(state_slave), 32'd0);

      // fresh write after reset
      bus_start();
      send_byte(8'hB6);
      bus_bit(1'b1, ack);
      check("fw_addr_ack", 32'(ack), 32'd0);
      send_byte(8'h5A);
      bus_bit(1'b1, ack);
      bus_stop();
      check("fw_rx_data", 32'(rx_data), 32'h5A);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
